// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
// Contents:
//   DEF_WIDTH, DEF_SEG_W : default operand and segment widths
//   seg_stage_t          : per-segment register record (valid, carry, ovf_src)
//   nseg()               : pipeline depth for a given width/segment split
// The partial sum of each segment is kept next to seg_stage_t, not inside it,
// because its width follows the SEG_W parameter of each instance.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG_W = 8;

  // ovf_src is the signed-overflow condition as if this segment held the
  // operand sign bits; only the top segment's value is used.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf_src;
  } seg_stage_t;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/seg_add_stage.sv
// One SEG_W-bit ripple segment of the pipelined adder plus its register.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : pipeline advance; the register holds when low
//   v_in            : valid bit travelling with this operation
//   a_seg, b_seg    : operand segments (b already conditioned for subtract)
//   c_in            : carry from the previous segment (or the carry-in)
//   stage_q         : registered valid / carry-out / overflow source
//   sum_q           : registered partial sum
module seg_add_stage
  import adder_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             v_in,
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             c_in,
  output seg_stage_t       stage_q,
  output logic [SEG_W-1:0] sum_q
);

  logic [SEG_W-1:0] gen;
  logic [SEG_W-1:0] prop;
  logic [SEG_W:0]   carry;
  logic [SEG_W-1:0] sum;
  seg_stage_t       stage_d;
  logic [SEG_W-1:0] sum_d;

  // Generate/propagate ripple through the segment.
  always_comb begin
    gen      = a_seg & b_seg;
    prop     = a_seg ^ b_seg;
    carry    = '0;
    carry[0] = c_in;
    for (int i = 0; i < SEG_W; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum = prop ^ carry[SEG_W-1:0];
  end

  always_comb begin
    stage_d = stage_q;
    sum_d   = sum_q;
    if (en) begin
      stage_d.valid   = v_in;
      stage_d.carry   = carry[SEG_W];
      stage_d.ovf_src = (a_seg[SEG_W-1] == b_seg[SEG_W-1]) &&
                        (sum[SEG_W-1] != a_seg[SEG_W-1]);
      sum_d           = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      sum_q   <= '0;
    end else begin
      stage_q <= stage_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined, segmented WIDTH-bit adder: the carry chain is cut into
// NSEG = WIDTH/SEG_W ripple segments with one register stage each.
// Latency NSEG cycles, one operation per cycle.
// Optional feature: define ADDER_SUB_EN to add the in_sub port
// (b is inverted and the carry-in forced to 1 for a subtract).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand beat handshake
//   in_a, in_b, in_cin   : operands and carry-in
//   in_sub               : subtract request (ADDER_SUB_EN only)
//   out_valid/out_ready  : result handshake
//   out_sum              : (a + b' + cin') mod 2^WIDTH
//   out_cout, out_ovf    : carry out of the MSB, signed overflow
//
// Handshake: a beat moves on a clock edge where valid & ready are both high;
// the sender keeps valid and data stable until then. All stages share one
// advance enable, adv = ~out_valid | out_ready, which is also in_ready, so the
// whole pipe either shifts as a unit or freezes as a unit.
module pipe_seg_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (WIDTH % SEG_W != 0) begin : g_bad_width
    $error("pipe_seg_adder: WIDTH must be a multiple of SEG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  seg_stage_t       st_q    [NSEG];
  logic [SEG_W-1:0] sum_q   [NSEG];
  logic [SEG_W-1:0] seg_out [NSEG];

`ifdef ADDER_SUB_EN
  always_comb begin
    b_eff   = in_b ^ {WIDTH{in_sub}};
    cin_eff = in_cin | in_sub;
  end
`else
  always_comb begin
    b_eff   = in_b;
    cin_eff = in_cin;
  end
`endif

  assign out_valid = st_q[NSEG-1].valid;
  assign out_cout  = st_q[NSEG-1].carry;
  assign out_ovf   = st_q[NSEG-1].ovf_src;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      out_sum[k*SEG_W +: SEG_W] = seg_out[k];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W-1:0] a_op;
    logic [SEG_W-1:0] b_op;
    logic             c_op;
    logic             v_op;

    if (k == 0) begin : g_first
      assign a_op = in_a[SEG_W-1:0];
      assign b_op = b_eff[SEG_W-1:0];
      assign c_op = cin_eff;
      assign v_op = in_valid;
    end else begin : g_skew
      // Segment k of the operands waits k cycles so it meets the carry
      // produced for the same operation by segment k-1.
      logic [SEG_W-1:0] a_sk_d [k];
      logic [SEG_W-1:0] a_sk_q [k];
      logic [SEG_W-1:0] b_sk_d [k];
      logic [SEG_W-1:0] b_sk_q [k];

      always_comb begin
        for (int j = 0; j < k; j++) begin
          a_sk_d[j] = a_sk_q[j];
          b_sk_d[j] = b_sk_q[j];
        end
        if (adv) begin
          a_sk_d[0] = in_a[k*SEG_W +: SEG_W];
          b_sk_d[0] = b_eff[k*SEG_W +: SEG_W];
          for (int j = 1; j < k; j++) begin
            a_sk_d[j] = a_sk_q[j-1];
            b_sk_d[j] = b_sk_q[j-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_sk_q[j] <= '0;
            b_sk_q[j] <= '0;
          end
        end else begin
          for (int j = 0; j < k; j++) begin
            a_sk_q[j] <= a_sk_d[j];
            b_sk_q[j] <= b_sk_d[j];
          end
        end
      end

      assign a_op = a_sk_q[k-1];
      assign b_op = b_sk_q[k-1];
      assign c_op = st_q[k-1].carry;
      assign v_op = st_q[k-1].valid;
    end

    seg_add_stage #(.SEG_W(SEG_W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .v_in    (v_op),
      .a_seg   (a_op),
      .b_seg   (b_op),
      .c_in    (c_op),
      .stage_q (st_q[k]),
      .sum_q   (sum_q[k])
    );

    if (k == NSEG - 1) begin : g_top
      assign seg_out[k] = sum_q[k];
    end else begin : g_deskew
      // Lower sum segments finish early and wait for the top segment.
      localparam int DK = NSEG - 1 - k;
      logic [SEG_W-1:0] ds_d [DK];
      logic [SEG_W-1:0] ds_q [DK];

      always_comb begin
        for (int j = 0; j < DK; j++) begin
          ds_d[j] = ds_q[j];
        end
        if (adv) begin
          ds_d[0] = sum_q[k];
          for (int j = 1; j < DK; j++) begin
            ds_d[j] = ds_q[j-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DK; j++) begin
            ds_q[j] <= '0;
          end
        end else begin
          for (int j = 0; j < DK; j++) begin
            ds_q[j] <= ds_d[j];
          end
        end
      end

      assign seg_out[k] = ds_q[DK-1];
    end
  end

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Self-checking bench for pipe_seg_adder (WIDTH=32, SEG_W=8, latency 4).
// Subtract vectors are applied when ADDER_SUB_EN is defined.
module tb_pipe_seg_adder;

  localparam int W    = 32;
  localparam int NSEG = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef ADDER_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W+1:0] exp_q[$];
  logic         mon_en = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  pipe_seg_adder #(.WIDTH(W), .SEG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // ---------------- reference model ----------------
  // Returns {ovf, cout, sum} from plain 33-bit arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   s;
    logic         ovf;
    bb  = sub ? ~b : b;
    c   = cin | sub;
    s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s[W], s[W-1:0]};
  endfunction

  function automatic logic cur_sub();
`ifdef ADDER_SUB_EN
    return in_sub;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got %h, required no result (t=%0t)",
                   {out_ovf, out_cout, out_sum}, $time);
        end else begin
          check("scoreboard", {30'd0, out_ovf, out_cout, out_sum}, {30'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, cur_sub()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    in_a   = a;
    in_b   = b;
    in_cin = cin;
`ifdef ADDER_SUB_EN
    in_sub = sub;
`endif
  endtask

  task automatic set_rand_op();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom();
    b = $urandom();
    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
    if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
    set_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Sends one op into an idle pipe and returns the cycles to out_valid.
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, output int lat);
    @(posedge clk); #1;
    set_op(a, b, cin, sub);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic [W-1:0] sum, input logic cout,
                         input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.sum = sum; v.cout = cout; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    logic acc;
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    add_vec(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    add_vec(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0);
    add_vec(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    add_vec(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
`ifdef ADDER_SUB_EN
    add_vec(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    add_vec(32'h0000_0009, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0006, 1'b1, 1'b0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed vectors with latency check
    for (int i = 0; i < tbl.size(); i++) begin
      send_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NSEG));
      check($sformatf("vec%0d_result", i), {30'd0, out_ovf, out_cout, out_sum},
            {30'd0, tbl[i].ovf, tbl[i].cout, tbl[i].sum});
    end
    drain("directed_drain");

    // 200 back-to-back random ops at full rate
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      set_rand_op();
      if (i >= NSEG) check("stream_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("stream_drain");

    // Fill the pipe with out_ready low, then stall 10 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_rand_op();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      acc = in_ready;
      if (c >= NSEG) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        e = exp_q[0];
        check("stall_hold", {30'd0, out_ovf, out_cout, out_sum}, {30'd0, e});
      end
      @(posedge clk); #1;
      if (acc) set_rand_op();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) set_rand_op();
    end
    in_valid = 1'b0;
    drain("stall_drain");

    // Reset with operations in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rand_op();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_reset_out_valid", 64'(out_valid), 64'd0);
    check("mid_reset_out_sum", 64'(out_sum), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ra = $urandom();
    rb = $urandom();
    rc = 1'($urandom_range(0, 1));
    send_one(ra, rb, rc, 1'b0, lat);
    check("post_reset_latency", 64'(lat), 64'(NSEG));
    check("post_reset_result", {30'd0, out_ovf, out_cout, out_sum},
          {30'd0, model(ra, rb, rc, 1'b0)});
    drain("final_drain");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
